// File: rtl/hex_word_rx_pkg.sv
// Shared types and character constants for the ASCII hex word receiver.
package hex_word_rx_pkg;

   // Parser states
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCUM   = 2'd1,
      DISCARD = 2'd2,
      HOLD    = 2'd3
   } state_t;

   // Character classes seen by the parser
   typedef enum logic [2:0] {
      C_HEX   = 3'd0,
      C_SEP   = 3'd1,
      C_NL    = 3'd2,
      C_CR    = 3'd3,
      C_OTHER = 3'd4
   } cls_t;

   localparam logic [7:0] CH_NL  = 8'h0A;
   localparam logic [7:0] CH_CR  = 8'h0D;
   localparam logic [7:0] CH_SEP = 8'h5F;

endpackage

// File: rtl/hex_char_class.sv
// Classifies one ASCII character and decodes its hex nibble value.
module hex_char_class
   import hex_word_rx_pkg::*;
(
   input  logic [7:0] i_char,
   output cls_t       o_cls,
   output logic [3:0] o_nib
);

   // Decode: letters share low nibble 1..6 for both cases, so +9 maps to 10..15
   always_comb begin
      o_cls = C_OTHER;
      o_nib = 4'd0;
      if (i_char >= 8'h30 && i_char <= 8'h39) begin
         o_cls = C_HEX;
         o_nib = i_char[3:0];
      end else if ((i_char >= 8'h61 && i_char <= 8'h66) ||
                   (i_char >= 8'h41 && i_char <= 8'h46)) begin
         o_cls = C_HEX;
         o_nib = i_char[3:0] + 4'd9;
      end else if (i_char == CH_SEP) begin
         o_cls = C_SEP;
      end else if (i_char == CH_NL) begin
         o_cls = C_NL;
      end else if (i_char == CH_CR) begin
         o_cls = C_CR;
      end
   end

endmodule

// File: rtl/hex_word_rx.sv
// Parses newline-terminated ASCII hex lines into words with digit count and error flag.
module hex_word_rx
   import hex_word_rx_pkg::*;
#(
   parameter  int DIGITS = 4,
   localparam int W      = 4 * DIGITS,
   localparam int CW     = $clog2(DIGITS + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [7:0]    in_char,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_word,
   output logic [CW-1:0] out_ndigits,
   output logic          out_err
);

   state_t        r_state,   w_state_nxt;
   logic [W-1:0]  r_acc,     w_acc_nxt;
   logic [CW-1:0] r_count,   w_count_nxt;
   logic          r_ovalid,  w_ovalid_nxt;
   logic [W-1:0]  r_oword,   w_oword_nxt;
   logic [CW-1:0] r_ondig,   w_ondig_nxt;
   logic          r_oerr,    w_oerr_nxt;

   cls_t          w_cls;
   logic [3:0]    w_nib;
   logic          w_take;
   logic [W-1:0]  w_shifted;

   hex_char_class u_class (
      .i_char (in_char),
      .o_cls  (w_cls),
      .o_nib  (w_nib)
   );

   // Ready depends only on registered state, never on out_ready
   assign w_take    = in_valid && (r_state != HOLD);
   assign w_shifted = W'({r_acc, w_nib});

   // Next-state and datapath decisions for the parser
   always_comb begin
      w_state_nxt  = r_state;
      w_acc_nxt    = r_acc;
      w_count_nxt  = r_count;
      w_ovalid_nxt = r_ovalid;
      w_oword_nxt  = r_oword;
      w_ondig_nxt  = r_ondig;
      w_oerr_nxt   = r_oerr;
      case (r_state)
         IDLE: begin
            if (w_take) begin
               if (w_cls == C_HEX) begin
                  w_acc_nxt   = w_shifted;
                  w_count_nxt = CW'(1);
                  w_state_nxt = ACCUM;
               end else if (w_cls == C_OTHER) begin
                  w_state_nxt = DISCARD;
               end
            end
         end
         ACCUM: begin
            if (w_take) begin
               if (w_cls == C_HEX) begin
                  if (r_count == CW'(DIGITS)) begin
                     w_state_nxt = DISCARD;
                  end else begin
                     w_acc_nxt   = w_shifted;
                     w_count_nxt = r_count + CW'(1);
                  end
               end else if (w_cls == C_NL) begin
                  w_oword_nxt  = r_acc;
                  w_ondig_nxt  = r_count;
                  w_oerr_nxt   = 1'b0;
                  w_ovalid_nxt = 1'b1;
                  w_state_nxt  = HOLD;
               end else if (w_cls == C_OTHER) begin
                  w_state_nxt = DISCARD;
               end
            end
         end
         DISCARD: begin
            if (w_take && w_cls == C_NL) begin
               w_oword_nxt  = '0;
               w_ondig_nxt  = '0;
               w_oerr_nxt   = 1'b1;
               w_ovalid_nxt = 1'b1;
               w_state_nxt  = HOLD;
            end
         end
         HOLD: begin
            if (r_ovalid && out_ready) begin
               w_ovalid_nxt = 1'b0;
               w_acc_nxt    = '0;
               w_count_nxt  = '0;
               w_state_nxt  = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State, accumulator and result registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_acc    <= '0;
         r_count  <= '0;
         r_ovalid <= 1'b0;
         r_oword  <= '0;
         r_ondig  <= '0;
         r_oerr   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_acc    <= w_acc_nxt;
         r_count  <= w_count_nxt;
         r_ovalid <= w_ovalid_nxt;
         r_oword  <= w_oword_nxt;
         r_ondig  <= w_ondig_nxt;
         r_oerr   <= w_oerr_nxt;
      end
   end

   assign in_ready    = (r_state != HOLD);
   assign out_valid   = r_ovalid;
   assign out_word    = r_oword;
   assign out_ndigits = r_ondig;
   assign out_err     = r_oerr;

endmodule
